// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use stalls, branch flush, memory wait.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/wait/flush event counters.
module hazard_ctrl_unit #(
  parameter int REG_AW  = 5,
  parameter int LU_CYC  = 1,
  parameter int MEM_TMO = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_memread,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_bubble,
  output logic              ex_mem_en,
  output logic              mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]       lu_stall_cnt,
  output logic [15:0]       mem_wait_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_LU  = 2'd1;
  localparam logic [1:0] S_MW  = 2'd2;

  localparam logic [3:0] LU_INIT = 4'(LU_CYC - 1);
  localparam logic [7:0] TMO     = 8'(MEM_TMO);
  localparam bit         MULTI   = (LU_CYC > 1);

  logic [1:0] r_state;
  logic [3:0] r_lu_cnt;
  logic [7:0] r_wait_cnt;
  logic       r_mem_err;

  logic [1:0] w_state_nxt;
  logic [3:0] w_lu_nxt;
  logic [7:0] w_wait_nxt;
  logic       w_err_nxt;

  logic w_lu_haz;
  logic w_mwait;
  logic w_stall_ctx;
  logic w_stall;
  logic w_sel_mw;
  logic w_sel_br;
  logic w_sel_st;
  logic w_sel_run;
  logic [5:0] w_ctl;

  assign w_lu_haz = ex_memread
                  & (ex_rt != '0)
                  & ((ex_rt == id_rs)
                  | (id_uses_rt & (ex_rt == id_rt)));

  assign w_mwait = mem_req & ~mem_ready;

  // A wait that interrupted a stall resumes the stall on the same cycle it ends
  assign w_stall_ctx = (r_state == S_LU)
                     | ((r_state == S_MW) & (r_lu_cnt != 4'd0));

  assign w_stall = w_stall_ctx | w_lu_haz;

  assign w_sel_mw  = w_mwait;
  assign w_sel_br  = ~w_mwait & branch_taken;
  assign w_sel_st  = ~w_mwait & ~branch_taken & w_stall;
  assign w_sel_run = ~w_mwait & ~branch_taken & ~w_stall;

  always_comb begin
    w_ctl = 6'b000010;
    if (rst_n) begin
      unique case (1'b1)
        w_sel_mw:  w_ctl = 6'b000000;
        w_sel_br:  w_ctl = 6'b111111;
        w_sel_st:  w_ctl = 6'b000111;
        w_sel_run: w_ctl = 6'b110101;
        default:   w_ctl = 6'b000010;
      endcase
    end
  end

  assign {pc_en, if_id_en, if_id_flush,
          id_ex_en, id_ex_bubble, ex_mem_en} = w_ctl;

  assign mem_err = r_mem_err;

  always_comb begin
    w_state_nxt = r_state;
    w_lu_nxt    = r_lu_cnt;
    w_wait_nxt  = r_wait_cnt;
    w_err_nxt   = r_mem_err;
    if (w_mwait) begin
      w_state_nxt = S_MW;
      if (r_wait_cnt != 8'hFF)
        w_wait_nxt = r_wait_cnt + 8'd1;
      if (w_wait_nxt >= TMO)
        w_err_nxt = 1'b1;
    end else begin
      w_wait_nxt = 8'd0;
      if (branch_taken) begin
        w_state_nxt = S_RUN;
        w_lu_nxt    = 4'd0;
      end else if (w_stall_ctx) begin
        if (r_lu_cnt <= 4'd1) begin
          w_state_nxt = S_RUN;
          w_lu_nxt    = 4'd0;
        end else begin
          w_state_nxt = S_LU;
          w_lu_nxt    = r_lu_cnt - 4'd1;
        end
      end else if (w_lu_haz && MULTI) begin
        w_state_nxt = S_LU;
        w_lu_nxt    = LU_INIT;
      end else begin
        w_state_nxt = S_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_lu_cnt   <= 4'd0;
      r_wait_cnt <= 8'd0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lu_cnt   <= w_lu_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_mem_err  <= w_err_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_lu_stall_cnt;
  logic [15:0] r_mem_wait_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lu_stall_cnt <= 16'd0;
      r_mem_wait_cnt <= 16'd0;
      r_flush_cnt    <= 16'd0;
    end else begin
      if (id_ex_bubble && !branch_taken && r_lu_stall_cnt != 16'hFFFF)
        r_lu_stall_cnt <= r_lu_stall_cnt + 16'd1;
      if (w_mwait && r_mem_wait_cnt != 16'hFFFF)
        r_mem_wait_cnt <= r_mem_wait_cnt + 16'd1;
      if (if_id_flush && r_flush_cnt != 16'hFFFF)
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign lu_stall_cnt = r_lu_stall_cnt;
  assign mem_wait_cnt = r_mem_wait_cnt;
  assign flush_cnt    = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit (LU_CYC=2, MEM_TMO=4).
// Expected vector: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_err}.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, branch_taken;
  logic       mem_req, mem_ready;
  logic       pc_en, if_id_en, if_id_flush;
  logic       id_ex_en, id_ex_bubble, ex_mem_en, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] lu_stall_cnt, mem_wait_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [6:0] exp_q[$];
  string      name_q[$];

  localparam logic [6:0] RUN  = 7'b1101010;
  localparam logic [6:0] BUB  = 7'b0001110;
  localparam logic [6:0] FRZ  = 7'b0000000;
  localparam logic [6:0] BR   = 7'b1111110;
  localparam logic [6:0] RST  = 7'b0000100;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(
    .REG_AW (5),
    .LU_CYC (2),
    .MEM_TMO(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_rt       (ex_rt),
    .ex_memread  (ex_memread),
    .branch_taken(branch_taken),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .pc_en       (pc_en),
    .if_id_en    (if_id_en),
    .if_id_flush (if_id_flush),
    .id_ex_en    (id_ex_en),
    .id_ex_bubble(id_ex_bubble),
    .ex_mem_en   (ex_mem_en),
    .mem_err     (mem_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .lu_stall_cnt(lu_stall_cnt),
    .mem_wait_cnt(mem_wait_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  task automatic step(input logic rn,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic [4:0] ert,
                      input logic mr, input logic br,
                      input logic rq, input logic rdy,
                      input logic [6:0] exp, input string nm);
    @(posedge clk);
    #1;
    rst_n        = rn;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = urt;
    ex_rt        = ert;
    ex_memread   = mr;
    branch_taken = br;
    mem_req      = rq;
    mem_ready    = rdy;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  task automatic idle(input logic [6:0] exp, input string nm);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, exp, nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [6:0] e;
      logic [6:0] a;
      string      n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {pc_en, if_id_en, if_id_flush, id_ex_en,
           id_ex_bubble, ex_mem_en, mem_err};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s got %b want %b", n, a, e);
      end
    end
  end

  initial begin
    rst_n = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rt = 0;
    ex_memread = 0; branch_taken = 0; mem_req = 0; mem_ready = 1;

    step(0, 0, 0, 0, 0, 0, 0, 0, 1, RST, "reset_hold");
    step(0, 5, 0, 0, 5, 1, 0, 0, 1, RST, "reset_ignores_haz");
    idle(RUN, "run_after_reset");

    step(1, 5, 0, 0, 5, 1, 0, 0, 1, BUB, "lu_rs_cyc1");
    step(1, 5, 0, 0, 5, 1, 0, 0, 1, BUB, "lu_rs_cyc2");
    idle(RUN, "lu_rs_done");

    step(1, 0, 0, 0, 0, 1, 0, 0, 1, RUN, "zero_exempt");
    step(1, 3, 7, 0, 7, 1, 0, 0, 1, RUN, "rt_unused");
    step(1, 3, 7, 1, 7, 1, 0, 0, 1, BUB, "lu_rt_cyc1");
    idle(BUB, "lu_rt_cyc2");
    idle(RUN, "lu_rt_done");

    step(1, 5, 0, 0, 5, 1, 1, 0, 1, BR,  "br_vs_lu");
    idle(RUN, "br_vs_lu_next");
    step(1, 6, 0, 0, 6, 1, 0, 0, 1, BUB, "lu_then_br");
    step(1, 0, 0, 0, 0, 0, 1, 0, 1, BR,  "br_in_stall");
    idle(RUN, "br_in_stall_next");

    step(1, 9, 0, 0, 9, 1, 0, 0, 1, BUB, "mw_lu_enter");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "mw_frz1");
    step(1, 0, 0, 0, 0, 0, 1, 1, 0, FRZ, "mw_frz2_br");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "mw_frz3");
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, BUB, "mw_resume_bub");
    idle(RUN, "mw_back_run");

    step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "tmo_w1");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "tmo_w2");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "tmo_w3");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "tmo_w4");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000001, "tmo_err_set");
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 7'b1101011, "tmo_err_sticky");
    idle(7'b1101011, "tmo_err_sticky2");

    step(1, 4, 0, 0, 4, 1, 0, 0, 1, 7'b0001111, "rst_lu_enter");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, RST, "rst_mid_stall");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, RST, "rst_mid_stall2");
    idle(RUN, "rst_release_run");
    idle(RUN, "rst_release_run2");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised, stateful pipeline hazard controller for the 5-stage MIPS core; supersedes the single-cycle load-use detector.
- Sits beside the ID stage. Drives PC, IF/ID, ID/EX and EX/MEM enables, bubble insertion and IF/ID flush.
- Adds multi-cycle load-use stalls, $zero exemption, taken-branch flush, and a variable-latency data-memory wait with a timeout error flag.

Parameters:
- REG_AW, 5, register-address width.
- LU_CYC, 1, bubbles inserted per load-use hazard; range 1..15.
- MEM_TMO, 64, maximum MEM_WAIT cycles before mem_err is set; range 1..255.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_rs  in  REG_AW  rs field of the instruction in IF/ID.
- id_rt  in  REG_AW  rt field of the instruction in IF/ID.
- id_uses_rt  in  1  instruction in ID reads rt as a source.
- ex_rt  in  REG_AW  destination of the instruction in ID/EX.
- ex_memread  in  1  instruction in ID/EX is a load.
- branch_taken  in  1  branch or jump resolved taken in EX.
- mem_req  in  1  instruction in EX/MEM accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC write enable.
- if_id_en  out  1  IF/ID write enable.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_en  out  1  ID/EX write enable.
- id_ex_bubble  out  1  ID/EX loads zeroed control signals.
- ex_mem_en  out  1  EX/MEM and MEM/WB write enable.
- mem_err  out  1  sticky memory-timeout flag.

Behaviour:
Reset:
- While rst_n=0: state=RUN, lu_cnt=0, wait_cnt=0, mem_err=0.
- Outputs during reset: pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_en=0, id_ex_bubble=1, if_id_flush=0.
- Reset asserted mid-stall or mid-wait aborts to RUN immediately.

Hazard terms:
- lu_haz = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & (ex_rt==id_rt))).
- Register 0 never causes a hazard.
- mwait = mem_req & ~mem_ready.

Outputs (Mealy, priority order, first match wins):
1. mwait: all enables 0, bubble=0, flush=0. Whole pipeline frozen; branch_taken and lu_haz are ignored this cycle.
2. branch_taken: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_bubble=1, ex_mem_en=1. Any pending load-use stall is cancelled because the dependent instruction is squashed.
3. lu_haz in RUN, or state=LU_STALL: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_bubble=1, ex_mem_en=1.
4. Otherwise: all enables 1, bubble=0, flush=0.

State machine (RUN, LU_STALL, MEM_WAIT), evaluated in priority order:
- Any state, mwait: go to MEM_WAIT. wait_cnt increments, saturating at 255.
  - wait_cnt reaching MEM_TMO sets mem_err, held until reset.
  - lu_cnt and the LU_STALL context are retained while waiting.
- MEM_WAIT, ~mwait: wait_cnt=0. Return to LU_STALL if lu_cnt!=0, else RUN.
- RUN, branch_taken: stay in RUN.
- RUN, lu_haz & LU_CYC>1: go to LU_STALL with lu_cnt=LU_CYC-1.
- RUN, lu_haz & LU_CYC=1: stay in RUN. The single bubble is issued and the load has moved on by the next cycle.
- LU_STALL, branch_taken: lu_cnt=0, go to RUN.
- LU_STALL, otherwise: decrement lu_cnt. Go to RUN when lu_cnt reaches 1 (the final stall cycle).

Stall length:
- A load-use hazard yields exactly LU_CYC bubble cycles, excluding frozen MEM_WAIT cycles.
- A new lu_haz is not evaluated while in LU_STALL.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds three outputs, each 16-bit, saturating, cleared by reset:
  - lu_stall_cnt: incremented each cycle with id_ex_bubble=1 and branch_taken=0.
  - mem_wait_cnt: incremented each mwait cycle.
  - flush_cnt: incremented each if_id_flush cycle.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Load-use: LU_CYC=2, ex_memread=1, ex_rt=5, id_rs=5 -> pc_en=0, if_id_en=0, id_ex_bubble=1 for exactly 2 cycles, then all enables 1.
- $zero exemption: ex_memread=1, ex_rt=0, id_rs=0 -> no stall. Also: id_uses_rt=0, ex_rt=id_rt=7, ex_memread=1 -> no stall.
- Branch vs load-use: branch_taken=1 in the same cycle as lu_haz -> if_id_flush=1, id_ex_bubble=1, pc_en=1; next cycle state is RUN with no stall.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles during LU_STALL (lu_cnt=1) -> all enables 0 for 3 cycles, then one more bubble cycle, then RUN.
- Timeout: MEM_TMO=4, mem_ready held 0 -> mem_err=1 after the 4th wait cycle; it stays 1 after mem_ready=1 until rst_n=0.
- Reset mid-stall: rst_n low asynchronously during LU_STALL -> outputs immediately take their reset values; after release, RUN with all enables 1.
